// File: rtl/mult_pipe_rs.sv
// Pipelined signed/unsigned multiplier with round-half-up scaling, saturation and a
// valid/ready handshake; PIPE registered stages, the last one scales and saturates.
module mult_pipe_rs #(
  parameter int unsigned A_W   = 8,
  parameter int unsigned B_W   = 8,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 0,
  parameter int unsigned PIPE  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [A_W-1:0]       din_a,
  input  logic [B_W-1:0]       din_b,
  input  logic                 din_signed,
  input  logic                 din_vld,
  output logic                 din_rdy,
  output logic [OUT_W-1:0]     dout,
  output logic [A_W+B_W-1:0]   dout_full,
  output logic                 dout_sat,
  output logic                 dout_signed,
  output logic                 dout_vld,
  input  logic                 dout_rdy
);

  localparam int unsigned W  = A_W + B_W;
  localparam int unsigned NS = PIPE - 1;
  localparam logic [W:0]  RND = (W+1)'((64'd1 << SHIFT) >> 1);

  logic [W-1:0]  p_q [NS];
  logic [NS-1:0] vld_q;
  logic [NS-1:0] sgn_q;

  logic                 stall;
  logic signed [A_W:0]  a_ext;
  logic signed [B_W:0]  b_ext;
  logic signed [W-1:0]  prod;
  logic [W-1:0]         p_last;
  logic                 s_last;
  logic signed [W:0]    t_ext;
  logic signed [W:0]    t_rnd;
  logic signed [W:0]    t_sh;
  logic                 ovf;
  logic [OUT_W-1:0]     sat_val;
  logic [OUT_W-1:0]     scaled;

  assign stall   = dout_vld && !dout_rdy;
  assign din_rdy = !stall;

  // One extra bit lets signed and unsigned operands share a single signed multiplier;
  // only the low W bits of the product are kept, so a W-bit modular multiply suffices.
  always_comb begin
    a_ext = {din_signed & din_a[A_W-1], din_a};
    b_ext = {din_signed & din_b[B_W-1], din_b};
    prod  = W'(a_ext) * W'(b_ext);
  end

  always_comb begin
    p_last = p_q[NS-1];
    s_last = sgn_q[NS-1];
    t_ext  = s_last ? {p_last[W-1], p_last} : {1'b0, p_last};
    t_rnd  = t_ext + RND;
    t_sh   = s_last ? (t_rnd >>> SHIFT) : (t_rnd >> SHIFT);
    if (s_last) begin
      ovf     = !((&t_sh[W:OUT_W-1]) || !(|t_sh[W:OUT_W-1]));
      sat_val = t_sh[W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      ovf     = |t_sh[W:OUT_W];
      sat_val = {OUT_W{1'b1}};
    end
    scaled = ovf ? sat_val : t_sh[OUT_W-1:0];
  end

  // The whole pipe advances or holds as one; bubbles are held too.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      dout        <= '0;
      dout_full   <= '0;
      dout_sat    <= 1'b0;
      dout_signed <= 1'b0;
      dout_vld    <= 1'b0;
    end else if (!stall) begin
      vld_q[0] <= din_vld;
      sgn_q[0] <= din_signed;
      p_q[0]   <= prod;
      for (int i = 1; i < NS; i++) begin
        vld_q[i] <= vld_q[i-1];
        sgn_q[i] <= sgn_q[i-1];
        p_q[i]   <= p_q[i-1];
      end
      dout_vld    <= vld_q[NS-1];
      dout        <= scaled;
      dout_full   <= p_last;
      dout_sat    <= ovf;
      dout_signed <= s_last;
    end
  end

endmodule

// File: tb/tb_mult_pipe_rs.sv
// Self-checking bench for mult_pipe_rs (8x8, OUT_W=8, SHIFT=4, PIPE=3) using directed
// vectors, randomized traffic and an arithmetic reference model.
module tb_mult_pipe_rs;

  localparam int A_W = 8, B_W = 8, OUT_W = 8, SHIFT = 4, PIPE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din_a, din_b;
  logic        din_signed, din_vld, din_rdy;
  logic [7:0]  dout;
  logic [15:0] dout_full;
  logic        dout_sat, dout_signed, dout_vld, dout_rdy;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] full;
    logic [7:0]  d;
    logic        sat;
    logic        s;
  } exp_t;

  exp_t exp_q[$];

  mult_pipe_rs #(
    .A_W  (A_W),
    .B_W  (B_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT),
    .PIPE (PIPE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din_a      (din_a),
    .din_b      (din_b),
    .din_signed (din_signed),
    .din_vld    (din_vld),
    .din_rdy    (din_rdy),
    .dout       (dout),
    .dout_full  (dout_full),
    .dout_sat   (dout_sat),
    .dout_signed(dout_signed),
    .dout_vld   (dout_vld),
    .dout_rdy   (dout_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // Reference: integer product, floor((P + 2^(S-1)) / 2^S), then clamp to the mode range.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
    longint av, bv, p, t, c, lo, hi, div;
    exp_t e;
    av = a;
    bv = b;
    if (s && a[7]) av = av - 256;
    if (s && b[7]) bv = bv - 256;
    p   = av * bv;
    div = longint'(1) << SHIFT;
    t   = p + div / 2;
    if (t >= 0) t = t / div;
    else t = -((-t + div - 1) / div);
    lo = s ? -(longint'(1) << (OUT_W - 1)) : 0;
    hi = s ? (longint'(1) << (OUT_W - 1)) - 1 : (longint'(1) << OUT_W) - 1;
    c  = (t < lo) ? lo : ((t > hi) ? hi : t);
    e.full = p[15:0];
    e.d    = c[7:0];
    e.sat  = (c != t);
    e.s    = s;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dout_vld !== 1'b0) begin
      failures++; $display("FAIL reset_dout_vld got=%b exp=0", dout_vld);
    end
    checks++;
    if (dout !== 8'h00) begin
      failures++; $display("FAIL reset_dout got=%h exp=00", dout);
    end
    checks++;
    if (dout_full !== 16'h0000) begin
      failures++; $display("FAIL reset_dout_full got=%h exp=0000", dout_full);
    end
    checks++;
    if (dout_sat !== 1'b0 || dout_signed !== 1'b0) begin
      failures++; $display("FAIL reset_flags got=%b%b exp=00", dout_sat, dout_signed);
    end
    checks++;
    if (din_rdy !== 1'b1) begin
      failures++; $display("FAIL reset_din_rdy got=%b exp=1", din_rdy);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0]  va [7] = '{8'd7, 8'd3, 8'hFD, 8'h80, 8'h7F, 8'hFF, 8'hFF};
    logic [7:0]  vb [7] = '{8'd8, 8'd8, 8'd8, 8'h80, 8'h80, 8'hFF, 8'hFF};
    logic        vs [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] ef [7] = '{16'h0038, 16'h0018, 16'hFFE8, 16'h4000, 16'hC080, 16'hFE01,
                            16'h0001};
    logic [7:0]  ed [7] = '{8'h04, 8'h02, 8'hFF, 8'h7F, 8'h80, 8'hFF, 8'h00};
    logic        es [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int edges;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      dout_rdy   = 1'b1;
      din_a      = va[i];
      din_b      = vb[i];
      din_signed = vs[i];
      din_vld    = 1'b1;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      din_vld = 1'b0;
      din_a   = 8'($urandom);
      din_b   = 8'($urandom);
      while (!dout_vld && edges < 10) begin
        @(posedge clk);
        edges++;
        @(negedge clk);
      end
      checks++;
      if (edges !== PIPE) begin
        failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, edges, PIPE);
      end
      checks++;
      if (dout_full !== ef[i]) begin
        failures++; $display("FAIL dir%0d_full got=%h exp=%h", i, dout_full, ef[i]);
      end
      checks++;
      if (dout !== ed[i]) begin
        failures++; $display("FAIL dir%0d_dout got=%h exp=%h", i, dout, ed[i]);
      end
      checks++;
      if (dout_sat !== es[i] || dout_signed !== vs[i]) begin
        failures++;
        $display("FAIL dir%0d_sat_mode got=%b%b exp=%b%b", i, dout_sat, dout_signed, es[i], vs[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, outs = 0, first = -1, last = -1;
    exp_t e;
    exp_q.delete();
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      dout_rdy = 1'b1;
      if (dout_vld) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_spurious got=%h exp=none", dout);
        end else begin
          e = exp_q.pop_front();
          if ({dout_full, dout, dout_sat, dout_signed} !== {e.full, e.d, e.sat, e.s}) begin
            failures++;
            $display("FAIL b2b_out%0d got=%h/%h/%b/%b exp=%h/%h/%b/%b", outs, dout_full, dout,
                     dout_sat, dout_signed, e.full, e.d, e.sat, e.s);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        outs++;
      end
      if (sent < 10) begin
        din_a      = 8'($urandom);
        din_b      = 8'($urandom);
        din_signed = (sent % 2 == 0);
        din_vld    = 1'b1;
      end else begin
        din_vld = 1'b0;
      end
      #1;
      if (din_vld && din_rdy) begin
        exp_q.push_back(model(din_a, din_b, din_signed));
        sent++;
      end
    end
    checks++;
    if (outs !== 10) begin
      failures++; $display("FAIL b2b_count got=%0d exp=10", outs);
    end
    checks++;
    if (last - first !== 9) begin
      failures++; $display("FAIL b2b_consecutive got=%0d exp=9", last - first);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0, outs = 0;
    logic [26:0] snap;
    bit have_snap = 1'b0;
    exp_t e;
    exp_q.delete();
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      dout_rdy = 1'b0;
      if (dout_vld) begin
        if (have_snap) begin
          checks++;
          if ({dout_vld, dout, dout_full, dout_sat, dout_signed} !== snap) begin
            failures++;
            $display("FAIL bp_stable got=%h exp=%h",
                     {dout_vld, dout, dout_full, dout_sat, dout_signed}, snap);
          end
        end else begin
          snap = {dout_vld, dout, dout_full, dout_sat, dout_signed};
          have_snap = 1'b1;
        end
      end
      if (sent < 6) begin
        din_a      = 8'($urandom);
        din_b      = 8'($urandom);
        din_signed = 1'($urandom);
        din_vld    = 1'b1;
      end else begin
        din_vld = 1'b0;
      end
      #1;
      if (din_vld && din_rdy) begin
        exp_q.push_back(model(din_a, din_b, din_signed));
        sent++;
      end
    end
    checks++;
    if (sent !== PIPE) begin
      failures++; $display("FAIL bp_held got=%0d exp=%0d", sent, PIPE);
    end
    checks++;
    if (din_rdy !== 1'b0 || dout_vld !== 1'b1) begin
      failures++; $display("FAIL bp_stall got=rdy%b vld%b exp=rdy0 vld1", din_rdy, dout_vld);
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      dout_rdy = 1'b1;
      if (dout_vld) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL bp_spurious got=%h exp=none", dout);
        end else begin
          e = exp_q.pop_front();
          if ({dout_full, dout, dout_sat, dout_signed} !== {e.full, e.d, e.sat, e.s}) begin
            failures++;
            $display("FAIL bp_out%0d got=%h/%h/%b/%b exp=%h/%h/%b/%b", outs, dout_full, dout,
                     dout_sat, dout_signed, e.full, e.d, e.sat, e.s);
          end
        end
        outs++;
      end
      if (sent < 6) begin
        din_a      = 8'($urandom);
        din_b      = 8'($urandom);
        din_signed = 1'($urandom);
        din_vld    = 1'b1;
      end else begin
        din_vld = 1'b0;
      end
      #1;
      if (din_vld && din_rdy) begin
        exp_q.push_back(model(din_a, din_b, din_signed));
        sent++;
      end
    end
    checks++;
    if (outs !== 6 || exp_q.size() !== 0) begin
      failures++; $display("FAIL bp_drain got=%0d left=%0d exp=6 left=0", outs, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int ghosts = 0, edges;
    exp_t e;
    dout_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      din_a      = 8'($urandom);
      din_b      = 8'($urandom);
      din_signed = 1'($urandom);
      din_vld    = 1'b1;
    end
    @(negedge clk);
    din_vld = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({dout_vld, dout, dout_full, dout_sat, dout_signed} !== 27'd0) begin
      failures++;
      $display("FAIL rst_mid_clear got=%b/%h/%h/%b/%b exp=all0", dout_vld, dout, dout_full,
               dout_sat, dout_signed);
    end
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (dout_vld) ghosts++;
    end
    checks++;
    if (ghosts !== 0) begin
      failures++; $display("FAIL rst_mid_ghost got=%0d exp=0", ghosts);
    end
    @(negedge clk);
    din_a      = 8'($urandom);
    din_b      = 8'($urandom);
    din_signed = 1'($urandom);
    din_vld    = 1'b1;
    e = model(din_a, din_b, din_signed);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    din_vld = 1'b0;
    while (!dout_vld && edges < 10) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checks++;
    if (edges !== PIPE) begin
      failures++; $display("FAIL rst_mid_latency got=%0d exp=%0d", edges, PIPE);
    end
    checks++;
    if ({dout_full, dout, dout_sat, dout_signed} !== {e.full, e.d, e.sat, e.s}) begin
      failures++;
      $display("FAIL rst_mid_value got=%h/%h/%b/%b exp=%h/%h/%b/%b", dout_full, dout, dout_sat,
               dout_signed, e.full, e.d, e.sat, e.s);
    end
  endtask

  initial begin
    rst        = 1'b1;
    din_a      = '0;
    din_b      = '0;
    din_signed = 1'b0;
    din_vld    = 1'b0;
    dout_rdy   = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
